// File: rtl/se_acc_pipe.sv
// Two-stage sign-extending adder/accumulator with a registered low/high carry split,
// valid/ready flow control, an accumulate mode and signed-overflow reporting.
module se_acc_pipe #(
  parameter int A_W  = 27,
  parameter int S_W  = 51,
  parameter int LO_W = 27
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [A_W-1:0] a,
  input  logic [S_W-1:0] b,
  input  logic           mode,
  input  logic           clr,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [S_W-1:0] sum,
  output logic           ovf
);

  localparam int HI_W = S_W - LO_W;

  function automatic logic signed [S_W-1:0] sign_ext(input logic signed [A_W-1:0] x);
    return {{(S_W-A_W){x[A_W-1]}}, x};
  endfunction

  function automatic logic signed_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  logic signed [S_W-1:0] ext_a;
  logic signed [S_W-1:0] opb;
  logic signed [S_W-1:0] acc;
  logic        [LO_W:0]  lo_add;
  logic        [HI_W-1:0] hi_add;
  logic signed [S_W-1:0] sum_nxt;
  logic                  ovf_nxt;

  logic                  vld_p1;
  logic        [LO_W-1:0] lo_p1;
  logic                  cy_p1;
  logic        [HI_W-1:0] ahi_p1;
  logic        [HI_W-1:0] bhi_p1;
  logic                  sa_p1;
  logic                  sb_p1;
  logic                  mode_p1;

  logic                  vld_p2;
  logic signed [S_W-1:0] sum_p2;
  logic                  ovf_p2;

  logic s2_adv, s1_adv, acc_busy, accept;

  assign s2_adv   = !vld_p2 || out_ready;
  assign s1_adv   = !vld_p1 || s2_adv;
  // A queued accumulate must write back before the next one may read acc.
  assign acc_busy = vld_p1 && mode_p1;
  assign in_ready = !rst && s1_adv && !(mode && acc_busy);
  assign accept   = in_valid && in_ready;

  // Stage 0 -> 1: operand select and low-segment add
  assign ext_a  = sign_ext(a);
  assign opb    = mode ? acc : b;
  assign lo_add = {1'b0, ext_a[LO_W-1:0]} + {1'b0, opb[LO_W-1:0]};

  always_ff @(posedge clk) begin
    if (accept) begin
      lo_p1   <= lo_add[LO_W-1:0];
      cy_p1   <= lo_add[LO_W];
      ahi_p1  <= ext_a[S_W-1:LO_W];
      bhi_p1  <= opb[S_W-1:LO_W];
      sa_p1   <= ext_a[S_W-1];
      sb_p1   <= opb[S_W-1];
      mode_p1 <= mode;
    end
  end

  // Stage 1 -> 2: high-segment add with registered carry, overflow detect
  assign hi_add  = ahi_p1 + bhi_p1 + HI_W'(cy_p1);
  assign sum_nxt = {hi_add, lo_p1};
  assign ovf_nxt = signed_ovf(sa_p1, sb_p1, sum_nxt[S_W-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      sum_p2 <= '0;
      ovf_p2 <= 1'b0;
      acc    <= '0;
    end else begin
      if (s1_adv) vld_p1 <= accept;
      if (s2_adv) begin
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          sum_p2 <= sum_nxt;
          ovf_p2 <= ovf_nxt;
        end
      end
      // clr wins over a same-edge write-back; the op still delivers its sum.
      if (clr)
        acc <= '0;
      else if (s2_adv && vld_p1 && mode_p1)
        acc <= sum_nxt;
    end
  end

  assign out_valid = vld_p2;
  assign sum       = sum_p2;
  assign ovf       = ovf_p2;

endmodule

// File: doc/se_acc_pipe.md
# se_acc_pipe

Parametrised, two-stage pipelined sign-extending adder/accumulator. It adds a narrow signed operand `a` to a wide signed operand `b`, or to an internal running accumulator, using a low/high split carry chain. It serves as the partial-sum combine and accumulate stage behind the DCIM adder tree. It adds valid/ready flow control, a registered split point, an accumulate mode and signed-overflow reporting.

## Interface
- `A_W`, default 27: width of narrow operand `a`, signed two's complement.
- `S_W`, default 51: width of `b`, `sum` and the accumulator, signed. Must satisfy S_W > A_W.
- `LO_W`, default 27: width of the low adder segment. Range 1 ≤ LO_W < S_W; the high segment is S_W−LO_W bits.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous reset, active-high.
- `in_valid`  in  1  input operands valid.
- `in_ready`  out  1  block accepts input this cycle.
- `a`  in  A_W  narrow signed operand.
- `b`  in  S_W  wide signed operand; ignored when `mode`=1.
- `mode`  in  1  0 = sum a+b; 1 = sum a+acc and write the result back to acc.
- `clr`  in  1  synchronous clear of the accumulator, independent of `in_valid`.
- `out_valid`  out  1  `sum`/`ovf` valid.
- `out_ready`  in  1  downstream accepts the result.
- `sum`  out  S_W  result, modulo 2^S_W.
- `ovf`  out  1  signed overflow of this result.

## Operation
- `a` is sign-extended to S_W bits: `{(S_W−A_W){a[A_W−1]}, a}`.
- Operand B = `b` when `mode`=0, or the accumulator register `acc` when `mode`=1. B is sampled at accept.
- Accept occurs when `in_valid` && `in_ready`.
- Stage 1 register S1: low sum = ext_a[LO_W−1:0] + B[LO_W−1:0]. S1 holds LO_W sum bits, the carry-out, ext_a and B high slices, both operand sign bits, and `mode`.
- Stage 2 register S2, the output register: high sum = ext_a_hi + B_hi + carry. `sum` = {high, low}.
  - `ovf` = (sign_a == sign_B) && (sum[S_W−1] != sign_a).
- Accumulator write-back:
  - When S1 advances into S2 holding a mode-1 op, `acc` ← that sum, on the same edge.
  - The accumulator wraps on overflow. `ovf` is reported but the value is not saturated.
- Accumulate interlock: `acc_busy` = S1 valid && S1.mode. A mode-1 input is not accepted while `acc_busy` is set. Mode-1 throughput is therefore 1 per 2 cycles; mode-0 throughput is 1 per cycle.
- Flow control:
  - s2_adv = !S2.valid || `out_ready`.
  - s1_adv = !S1.valid || s2_adv.
  - `in_ready` = !`rst` && s1_adv && !(`mode` && `acc_busy`).
  - The combinational dependence of `in_ready` on `mode` is intended.
- `clr`:
  - `acc` ← 0 on the next edge.
  - `clr` has priority over a same-cycle write-back; that op's `sum` is still delivered, but acc ends at 0.
  - Ops accepted after the `clr` edge see acc = 0.
- Ordering: results leave in accept order. No reordering and no drops.

## Timing
- Latency 2: an op accepted at edge N has `out_valid`=1 from edge N+1 of S2, i.e. visible in the cycle after edge N+2 minus one. Concretely, `out_valid` is high in cycle N+2 when there are no stalls.
- Stall: while `out_valid` && !`out_ready`, `sum`, `ovf` and `out_valid` hold stable. S1 holds if full, and `in_ready` is 0 when both stages are full. At most 2 ops are in flight.
- A same-cycle S2 drain and S1 advance with a new accept is allowed, giving full throughput in mode 0.
- Reset, applied at any time including mid-operation:
  - S1/S2 valids = 0.
  - `out_valid` = 0, `sum` = 0, `ovf` = 0, `acc` = 0.
  - `in_ready` = 0 while `rst` is high, and 1 in the first cycle after release.
  - In-flight ops are discarded with no partial output.
- No combinational path from `a`/`b` to `sum`. `in_ready` depends combinationally on `out_ready`, `mode` and `rst`.

## Test plan
- Mode 0, a=27'h7FFFFFF (−1), b=5 → sum=4, ovf=0, `out_valid` exactly 2 cycles after accept.
- Split carry, LO_W=27: a=1, b=51'h0000007FFFFFF → sum=51'h0000008000000, carry into the high segment; repeat with LO_W=8, same operands → same sum.
- Overflow: a=1, b=51'h3FFFFFFFFFFFF → sum=51'h4000000000000, ovf=1. Then a=27'h4000000 (−2^26), b=51'h4000000000000 → sum=51'h3FFFFFC000000, ovf=1.
- Accumulate: pulse `clr`, then mode-1 with a=3, −1 (27'h7FFFFFF), 10 held on `in_valid` continuously:
  - `in_ready` low on each cycle following an accept.
  - sums 3, 2, 12 are output in order, and acc=12.
  - `clr` asserted on the last write-back edge → sum=12 is still output, acc=0, and the next a=4 gives sum=4.
- Backpressure: `out_ready`=0 for 4 cycles while 3 mode-0 ops are offered:
  - exactly 2 ops are accepted;
  - `sum` stays stable;
  - `in_ready`=0 once both stages are full;
  - on release, results drain in order and the third op is accepted.
- Reset mid-flight: assert `rst` with both stages valid and acc=7 → next cycle `out_valid`=0, `sum`=0, `ovf`=0, acc=0. After release, `in_ready`=1 and the first op's result is correct.
